// File: rtl/imem_responder_if.sv
// imem_responder_if: word-wide system memory read bus.
// Master issues req/addr and holds them until a one-cycle ack returns data.
interface imem_responder_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data
  );
endinterface

// File: rtl/imem_responder.sv
// imem_responder: direct-mapped I-cache for fetch, whole-line refill, CPU stall.
// Optional fence.i flush port when IMEM_FLUSH_EN is defined.
module imem_responder #(
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter logic [31:0] MEM_BASE   = 32'h0000_0000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [31:0]      i_if_pc,
  output logic [31:0]      o_data_out,
  output logic             o_clk_ce,
`ifdef IMEM_FLUSH_EN
  input  logic             i_flush,
`endif
  imem_responder_if.master mem
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int LN_W  = 30 - OFF_W;
  localparam int TAG_W = LN_W - IDX_W;
  localparam int DEPTH = NUM_LINES * LINE_WORDS;
  localparam logic [OFF_W-1:0] OFF_LAST =
    OFF_W'(LINE_WORDS - 1);

  typedef enum logic {
    S_IDLE,
    S_FILL
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [OFF_W-1:0]     cnt_q;
  logic [OFF_W-1:0]     cnt_d;
  logic [OFF_W-1:0]     cnt_nx;
  logic [LN_W-1:0]      line_q;
  logic [LN_W-1:0]      line_d;
  logic                 req_q;
  logic                 req_d;
  logic [31:0]          addr_q;
  logic [31:0]          addr_d;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];
  logic [31:0]          data_q [DEPTH];

  logic [OFF_W-1:0]     pc_off;
  logic [LN_W-1:0]      pc_line;
  logic [IDX_W-1:0]     pc_idx;
  logic [TAG_W-1:0]     pc_tag;
  logic [IDX_W-1:0]     fill_idx;
  logic [TAG_W-1:0]     fill_tag;

  logic                 hit;
  logic                 flush_now;
  logic                 flush_pend;
  logic                 flush_all;
  logic                 fill_we;
  logic                 fill_done;
  logic                 unused_pc;

  assign pc_off    = i_if_pc[OFF_W+1:2];
  assign pc_line   = i_if_pc[31:OFF_W+2];
  assign pc_idx    = pc_line[IDX_W-1:0];
  assign pc_tag    = pc_line[LN_W-1:IDX_W];
  assign fill_idx  = line_q[IDX_W-1:0];
  assign fill_tag  = line_q[LN_W-1:IDX_W];
  assign cnt_nx    = cnt_q + 1'b1;
  assign unused_pc = ^i_if_pc[1:0];

`ifdef IMEM_FLUSH_EN
  logic pend_q;

  assign flush_now  = i_flush;
  assign flush_pend = pend_q;

  // A flush seen mid-fill is applied when the line lands.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_q <= 1'b0;
    end else if (fill_done) begin
      pend_q <= 1'b0;
    end else if (state_q == S_FILL && i_flush) begin
      pend_q <= 1'b1;
    end
  end
`else
  assign flush_now  = 1'b0;
  assign flush_pend = 1'b0;
`endif

  assign hit = (state_q == S_IDLE)
            && valid_q[pc_idx]
            && (tag_q[pc_idx] == pc_tag);

  assign o_clk_ce   = hit && !flush_now;
  assign o_data_out = o_clk_ce
                    ? data_q[{pc_idx, pc_off}]
                    : 32'h0;

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    line_d    = line_q;
    req_d     = req_q;
    addr_d    = addr_q;
    fill_we   = 1'b0;
    fill_done = 1'b0;
    flush_all = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (flush_now) begin
          flush_all = 1'b1;
        end else if (!hit) begin
          state_d = S_FILL;
          cnt_d   = '0;
          line_d  = pc_line;
          req_d   = 1'b1;
          addr_d  = MEM_BASE
                  + {pc_line, {OFF_W{1'b0}}, 2'b00};
        end
      end
      S_FILL: begin
        if (req_q && mem.mem_ack) begin
          fill_we = 1'b1;
          cnt_d   = cnt_nx;
          if (cnt_q == OFF_LAST) begin
            state_d   = S_IDLE;
            req_d     = 1'b0;
            fill_done = 1'b1;
            flush_all = flush_pend || flush_now;
          end else begin
            addr_d = MEM_BASE
                   + {line_q, cnt_nx, 2'b00};
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      req_q   <= 1'b0;
      addr_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
    end else if (flush_all) begin
      valid_q <= '0;
    end else if (fill_done) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Storage arrays carry no reset; valid bits guard them.
  always_ff @(posedge i_clk) begin
    if (!i_rst && fill_we) begin
      data_q[{fill_idx, cnt_q}] <= mem.mem_data;
    end
    if (!i_rst && fill_done) begin
      tag_q[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed bench with a residency model and memory image.
// Bus slave acks with programmable latency; a per-cycle checker guards data.
module tb_imem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] data_out;
  logic        clk_ce;
`ifdef IMEM_FLUSH_EN
  logic        flush;
`endif

  imem_responder_if bus ();

  imem_responder dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_if_pc    (pc),
    .o_data_out (data_out),
    .o_clk_ce   (clk_ce),
`ifdef IMEM_FLUSH_EN
    .i_flush    (flush),
`endif
    .mem        (bus)
  );

  int          n_checks;
  int          n_fail;
  int          ack_lat;
  bit          spur;
  bit          run_cmp;
  int          wait_cnt;
  logic [31:0] hold_addr;
  logic [31:0] acc_q [$];
  bit          m_valid [16];
  logic [23:0] m_tag [16];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Bus slave: ack after ack_lat request cycles, address must hold meanwhile.
  initial begin
    bus.mem_ack  = 1'b0;
    bus.mem_data = 32'h0;
    wait_cnt     = 0;
    hold_addr    = 32'h0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_req === 1'b1) begin
        if (wait_cnt == 0) hold_addr = bus.mem_addr;
        else chk("addr_hold", bus.mem_addr, hold_addr);
        wait_cnt++;
        if (wait_cnt >= ack_lat) begin
          bus.mem_ack  = 1'b1;
          bus.mem_data = mem_word(bus.mem_addr);
          acc_q.push_back(bus.mem_addr);
          wait_cnt     = 0;
        end
      end else begin
        wait_cnt = 0;
        if (spur) begin
          bus.mem_ack  = 1'b1;
          bus.mem_data = 32'hBAD0_BAD0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      if (clk_ce === 1'b1) chk("cmp_data", data_out, mem_word(pc));
      else chk("cmp_stall_data", data_out, 32'h0);
    end
  end

  task automatic access(input logic [31:0] a,
                        input logic [31:0] lit_data,
                        input int lit_stall);
    int          idx;
    logic [23:0] tg;
    bit          exp_hit;
    int          exp_stall;
    int          stall;
    idx       = int'(a[7:4]);
    tg        = a[31:8];
    exp_hit   = m_valid[idx] && (m_tag[idx] == tg);
    exp_stall = exp_hit ? 0 : 1 + 4 * ack_lat;
    acc_q.delete();
    pc    = a;
    stall = 0;
    @(negedge clk);
    while (clk_ce !== 1'b1 && stall < 300) begin
      stall++;
      @(negedge clk);
    end
    chk("stall_model", 32'(stall), 32'(exp_stall));
    if (lit_stall >= 0) chk("stall_lit", 32'(stall), 32'(lit_stall));
    chk("data_lit", data_out, lit_data);
    if (exp_hit) begin
      chk("hit_noreq", {31'b0, bus.mem_req}, 32'h0);
    end else begin
      chk("fill_cnt", 32'(acc_q.size()), 32'd4);
      if (acc_q.size() == 4) begin
        for (int k = 0; k < 4; k++) begin
          chk("fill_addr", acc_q[k], {a[31:4], 4'h0} + 32'(4 * k));
        end
      end
    end
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
`ifdef IMEM_FLUSH_EN
    int  stall;
    bit  fl_done;
    flush = 1'b0;
`endif
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    pc       = 32'h0;
    ack_lat  = 1;
    spur     = 1'b0;
    run_cmp  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
    end

    @(posedge clk);
    #1;
    run_cmp = 1'b1;
    @(negedge clk);
    chk("rst_req", {31'b0, bus.mem_req}, 32'h0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    chk("rst_ce", {31'b0, clk_ce}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    access(32'h0000_0000, 32'hFFFF_0000, 5);
    access(32'h0000_0004, 32'hFFFB_0004, 0);
    access(32'h0000_0008, 32'hFFF7_0008, 0);
    access(32'h0000_000C, 32'hFFF3_000C, 0);
    access(32'h0000_0100, 32'hFEFF_0100, 5);
    access(32'h0000_0000, 32'hFFFF_0000, 5);

    ack_lat = 4;
    access(32'h0000_0040, 32'hFFBF_0040, 17);
    access(32'h0000_004C, 32'hFFB3_004C, 0);

    spur = 1'b1;
    access(32'h0000_0044, 32'hFFBB_0044, 0);
    access(32'h0000_0048, 32'hFFB7_0048, 0);
    spur = 1'b0;

    ack_lat = 1;
    acc_q.delete();
    pc    = 32'h0000_0200;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (acc_q.size() < 2 && guard < 50);
    chk("midfill_reach", 32'(acc_q.size() >= 2), 32'd1);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    spur = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mr_req", {31'b0, bus.mem_req}, 32'h0);
    chk("mr_addr", bus.mem_addr, 32'h0);
    chk("mr_ce", {31'b0, clk_ce}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    access(32'h0000_0200, 32'hFDFF_0200, 5);
    spur = 1'b0;
    access(32'h0000_0044, 32'hFFBB_0044, 5);

`ifdef IMEM_FLUSH_EN
    access(32'h0000_0000, 32'hFFFF_0000, 5);
    access(32'h0000_0000, 32'hFFFF_0000, 0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ce", {31'b0, clk_ce}, 32'h0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    access(32'h0000_0000, 32'hFFFF_0000, 5);

    acc_q.delete();
    pc      = 32'h0000_0300;
    stall   = 0;
    fl_done = 1'b0;
    @(negedge clk);
    while (clk_ce !== 1'b1 && stall < 300) begin
      stall++;
      flush = (acc_q.size() == 2) && !fl_done;
      if (flush) fl_done = 1'b1;
      @(negedge clk);
    end
    flush = 1'b0;
    chk("flfill_stall", 32'(stall), 32'd10);
    chk("flfill_acks", 32'(acc_q.size()), 32'd8);
    chk("flfill_data", data_out, 32'hFCFF_0300);
    m_valid[0] = 1'b1;
    m_tag[0]   = 24'h3;
    @(posedge clk);
    #1;
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
